// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 sequencer: owns state/key registers and the round counter,
// and time-multiplexes one external round datapath over all NR rounds.
module aes_iter_ctrl #(
  parameter int NR  = 10,
  parameter int RCW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [127:0]     in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             busy,
  output logic [RCW-1:0]   dp_rc,
  output logic [127:0]     dp_state,
  output logic [127:0]     dp_key,
  output logic             dp_last,
  input  logic [127:0]     dp_state_out,
  input  logic [127:0]     dp_key_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } fsm_e;

  localparam logic [RCW-1:0] LAST_RND = RCW'(NR - 1);

  fsm_e           fsm_q,       fsm_d;
  logic [RCW-1:0] rnd_q,       rnd_d;
  logic [127:0]   state_reg_q, state_reg_d;
  logic [127:0]   key_reg_q,   key_reg_d;
  logic [127:0]   out_data_q,  out_data_d;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      fsm_q       <= S_IDLE;
      rnd_q       <= '0;
      state_reg_q <= '0;
      key_reg_q   <= '0;
      out_data_q  <= '0;
    end else begin
      fsm_q       <= fsm_d;
      rnd_q       <= rnd_d;
      state_reg_q <= state_reg_d;
      key_reg_q   <= key_reg_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first, so no path through the case infers a latch.
    fsm_d       = fsm_q;
    rnd_d       = rnd_q;
    state_reg_d = state_reg_q;
    key_reg_d   = key_reg_q;
    out_data_d  = out_data_q;

    unique case (fsm_q)
      S_IDLE: begin
        // Initial AddRoundKey happens here; round 1 starts on the next cycle.
        if (in_valid) begin
          state_reg_d = in_data ^ in_key;
          key_reg_d   = in_key;
          rnd_d       = '0;
          fsm_d       = S_RUN;
        end
      end

      S_RUN: begin
        state_reg_d = dp_state_out;
        key_reg_d   = dp_key_out;
        if (rnd_q == LAST_RND) begin
          out_data_d = dp_state_out;
          fsm_d      = S_DONE;
        end else begin
          rnd_d = rnd_q + 1'b1;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          fsm_d = S_IDLE;
        end
      end

      default: fsm_d = S_IDLE;
    endcase
  end

  // Datapath drive comes from registers only; dp_last is gated so it is low outside RUN.
  assign in_ready  = (fsm_q == S_IDLE);
  assign out_valid = (fsm_q == S_DONE);
  assign busy      = (fsm_q != S_IDLE);
  assign out_data  = out_data_q;
  assign dp_rc     = rnd_q;
  assign dp_state  = state_reg_q;
  assign dp_key    = key_reg_q;
  assign dp_last   = (fsm_q == S_RUN) && (rnd_q == LAST_RND);

endmodule
